// File: rtl/redmule_cfg_slave_if.sv
// Peripheral request/response bus between a config master and redmule_cfg_slave.
// Requests use req/gnt; the single-beat read response comes back on r_valid/r_id.
interface redmule_cfg_slave_if #(
    parameter int unsigned SysDataWidth = 32,
    parameter int unsigned IdWidth      = 8
);
    logic                      req;
    logic                      gnt;
    logic [31:0]               add;
    logic                      wen;
    logic [SysDataWidth/8-1:0] be;
    logic [SysDataWidth-1:0]   data;
    logic [IdWidth-1:0]        id;
    logic [SysDataWidth-1:0]   r_data;
    logic                      r_valid;
    logic [IdWidth-1:0]        r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/redmule_cfg_slave.sv
// Config slave for the RedMulE engine: shadow/active register banks plus a job-start FSM.
// Latency: grant in the request cycle, read data/r_valid one cycle later, start_o one cycle after a trigger.
// Backpressure: only a trigger write while a job runs is stalled (gnt=0); all other requests are granted.
module redmule_cfg_slave #(
    parameter int unsigned SysDataWidth = 32,
    parameter int unsigned NumCfgRegs   = 6,
    parameter logic [31:0] CfgBase      = 32'h40,
    parameter int unsigned IdWidth      = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clear_i,
    redmule_cfg_slave_if.slave                        periph,
    output logic                                      cfg_complete_o,
    output logic                                      start_o,
    output logic [NumCfgRegs-1:0][SysDataWidth-1:0]   cfg_o,
    output logic                                      busy_o,
    input  logic                                      done_i
);
    localparam int unsigned BeWidth = SysDataWidth / 8;
    localparam int unsigned IdxW    = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReady   = 2'd1,
        StRunning = 2'd2
    } state_e;

    state_e                                  state_q, state_d;
    logic [NumCfgRegs-1:0][SysDataWidth-1:0] shadow_q, shadow_d;
    logic [NumCfgRegs-1:0][SysDataWidth-1:0] active_q, active_d;
    logic [NumCfgRegs-1:0]                   mask_q, mask_d;
    logic                                    start_q, start_d;
    logic                                    r_valid_q, r_valid_d;
    logic [SysDataWidth-1:0]                 r_data_q, r_data_d;
    logic [IdWidth-1:0]                      r_id_q, r_id_d;

    // Decode works on word addresses; the byte offset bits never select anything.
    logic [29:0]     word_addr;
    logic [29:0]     cfg_off;
    logic [IdxW-1:0] cfg_idx;
    logic            is_cfg, is_trig, is_stat;
    logic            stall, wr, rd;
    logic            unused_addr_bits;

    assign word_addr        = periph.add[31:2];
    assign unused_addr_bits = ^periph.add[1:0];
    assign cfg_off          = word_addr - CfgBase[31:2];
    assign cfg_idx          = cfg_off[IdxW-1:0];
    assign is_cfg           = (word_addr >= CfgBase[31:2]) && (cfg_off < 30'(NumCfgRegs));
    assign is_trig          = (word_addr == 30'd0);
    assign is_stat          = (word_addr == 30'd1);

    assign stall      = is_trig && !periph.wen && (state_q == StRunning);
    assign periph.gnt = periph.req && !stall && !rst_i && !clear_i;
    assign wr         = periph.gnt && !periph.wen;
    assign rd         = periph.gnt && periph.wen;

    assign cfg_complete_o = &mask_q;
    assign busy_o         = (state_q == StRunning);
    assign start_o        = start_q;
    assign cfg_o          = active_q;
    assign periph.r_valid = r_valid_q;
    assign periph.r_data  = r_data_q;
    assign periph.r_id    = r_id_q;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        mask_d    = mask_q;
        start_d   = 1'b0;
        r_valid_d = rd;
        r_data_d  = r_data_q;
        r_id_d    = r_id_q;

        if (rd) begin
            r_id_d   = periph.id;
            r_data_d = '0;
            if (is_stat) begin
                r_data_d[3:0] = {busy_o, cfg_complete_o, state_q};
            end else if (is_cfg) begin
                r_data_d = shadow_q[cfg_idx];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (&mask_q) state_d = StReady;
            end
            StReady: begin
                if (wr && is_trig) begin
                    state_d  = StRunning;
                    active_d = shadow_q;
                    mask_d   = '0;
                    start_d  = 1'b1;
                end
            end
            StRunning: begin
                if (done_i) state_d = (&mask_q) ? StReady : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Applied after the trigger copy so a word written alongside it belongs to the next job.
        if (wr && is_cfg) begin
            for (int b = 0; b < int'(BeWidth); b++) begin
                if (periph.be[b]) shadow_d[cfg_idx][8*b +: 8] = periph.data[8*b +: 8];
            end
            mask_d[cfg_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            active_q  <= '0;
            mask_q    <= '0;
            start_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            mask_q    <= mask_d;
            start_q   <= start_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_id_q    <= r_id_d;
        end
    end
endmodule
